ppa_multiword_seq: RTL and testbench
====================================

Name: ppa_multiword_seq

Overview:
- Word-serial sequencer that drives one external WIDTH-bit parallel-prefix adder (default 21-bit Sklansky) to add or subtract WORDS*WIDTH-bit operands.
- Processes one word per cycle, LSW first, and carries between words through an internal carry register.
- Uses valid/ready handshakes on both sides.
- Sits between a multi-precision operand source (e.g. a modular-arithmetic unit) and the shared prefix adder.

Parameters:
- WIDTH, 21, bit width of the external adder and of one operand word.
- WORDS, 4, number of words per operand; legal range is WORDS >= 1.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept a request.
- in_a  input  WORDS*WIDTH  operand A; word i is bits [i*WIDTH +: WIDTH].
- in_b  input  WORDS*WIDTH  operand B.
- in_cin  input  1  carry-in for add; ignored when in_sub=1.
- in_sub  input  1  0: S = A + B + cin; 1: S = A - B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  WORDS*WIDTH  result, modulo 2^(WORDS*WIDTH).
- out_cout  output  1  final carry; for subtract, 1 means no borrow (A >= B).
- busy  output  1  high in RUN or DONE.
- add_a  output  WIDTH  to adder input A.
- add_b  output  WIDTH  to adder input B.
- add_cin  output  1  to adder carry-in.
- add_s  input  WIDTH  from adder sum; combinational, same cycle.
- add_cout  input  1  from adder carry-out; combinational, same cycle.

Behaviour:
- Reset (async assert, rst_n=0):
  - state=IDLE; idx, carry, operand and result registers cleared.
  - in_ready=1, out_valid=0, out_sum=0, out_cout=0, busy=0.
  - add_a, add_b, add_cin driven 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: capture in_a into A_reg.
  - If in_sub=0, capture in_b into B_reg as-is and set carry<=in_cin.
  - If in_sub=1, capture ~in_b into B_reg and set carry<=1.
  - Set idx<=0 and go to RUN.
- RUN:
  - in_ready=0.
  - add_a = A_reg word[idx], add_b = B_reg word[idx], add_cin = carry.
  - Each cycle: result word[idx] <= add_s and carry <= add_cout.
  - If idx==WORDS-1, go to DONE; otherwise idx<=idx+1.
- DONE:
  - out_valid=1; out_sum and out_cout (= carry) held stable.
  - On out_ready, go to IDLE; out_valid drops the next cycle.
  - No same-cycle re-accept.
- Adder outputs are driven 0 outside RUN, so the shared adder sees quiet inputs.
- Latency: out_valid rises exactly WORDS cycles after the accept edge.
- Minimum op period: WORDS+2 cycles.
- WORDS=1: RUN lasts one cycle.
- idx width: clog2(WORDS), minimum 1 bit.
- in_valid outside IDLE is ignored; no capture, no queueing.
- Backpressure: DONE may be held indefinitely; out_sum, out_cout and out_valid must not change.
- out_sum reflects the last completed op until overwritten word by word during the next RUN.
- Reset mid-RUN or mid-DONE: the operation is aborted and discarded, and the reset state above applies.
  - No out_valid pulse follows release.
  - in_ready=1 on the first cycle after release.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Test Plan:
1. Assert reset, release -> in_ready=1, out_valid=0, busy=0, add_a/add_b/add_cin=0, out_sum=0.
2. Ripple case, WIDTH=21, WORDS=4: A=2^84-1, B=0, cin=1, add -> add_cin sequence 1,1,1,1 in RUN; out_sum=0, out_cout=1; out_valid exactly 4 cycles after accept.
3. Subtract:
   - A=5, B=3 -> out_sum=2, out_cout=1.
   - A=3, B=5 -> out_sum=2^84-2, out_cout=0.
   - A=B=0x123456789ABCDEF012345 -> out_sum=0, out_cout=1.
4. Backpressure: hold out_ready=0 for 10 cycles and pulse in_valid with new operands -> out_sum/out_cout stable, in_ready=0, new request not captured; after out_ready=1, IDLE, then the new request is accepted.
5. Assert rst_n=0 while in RUN at idx=2 -> outputs return to reset values immediately; after release no out_valid, in_ready=1; the next op computes correctly.
6. Attach a behavioral WIDTH-bit adder and run 50 random ops (random in_sub, cin) -> {out_cout, out_sum} matches golden A+B+cin or A+~B+1 (modulo 2^(84+1)) every time; pass rate 100%.

Source files
------------

// File: rtl/ppa_multiword_seq.sv
// Word-serial add/subtract sequencer that drives one external WIDTH-bit prefix adder,
// stepping LSW first through WORDS words and chaining the carry through a register.
module ppa_multiword_seq #(
    parameter int WIDTH = 21,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORDS*WIDTH-1:0] in_a,
    input  logic [WORDS*WIDTH-1:0] in_b,
    input  logic                   in_cin,
    input  logic                   in_sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORDS*WIDTH-1:0] out_sum,
    output logic                   out_cout,
    output logic                   busy,
    output logic [WIDTH-1:0]       add_a,
    output logic [WIDTH-1:0]       add_b,
    output logic                   add_cin,
    input  logic [WIDTH-1:0]       add_s,
    input  logic                   add_cout
);

    localparam int N    = WORDS * WIDTH;
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic [N-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;

    // Next-state and datapath update for the IDLE/RUN/DONE sequencer
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d = in_a;
                    // Subtract is A + ~B + 1, so the carry register seeds the +1
                    if (in_sub) begin
                        b_d     = ~in_b;
                        carry_d = 1'b1;
                    end else begin
                        b_d     = in_b;
                        carry_d = in_cin;
                    end
                    idx_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                sum_d[idx_q*WIDTH +: WIDTH] = add_s;
                carry_d = add_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = add_cout;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    // State, operand, result and handshake registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Adder inputs come only from registers and stay quiet outside RUN
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state_q == S_RUN) begin
            add_a   = a_q[idx_q*WIDTH +: WIDTH];
            add_b   = b_q[idx_q*WIDTH +: WIDTH];
            add_cin = carry_q;
        end else begin
            add_a   = '0;
            add_b   = '0;
            add_cin = 1'b0;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

endmodule

// File: tb/tb_ppa_multiword_seq.sv
// Directed plus randomized bench for ppa_multiword_seq with a behavioural adder attached
// and a plain-arithmetic multi-precision reference.
module tb_ppa_multiword_seq;

    localparam int WIDTH = 21;
    localparam int WORDS = 4;
    localparam int N     = WIDTH * WORDS;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [N-1:0]     in_a = '0;
    logic [N-1:0]     in_b = '0;
    logic             in_cin = 1'b0;
    logic             in_sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [N-1:0]     out_sum;
    logic             out_cout;
    logic             busy;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_s;
    logic             add_cout;

    int n_tests = 0;
    int n_fail  = 0;

    ppa_multiword_seq #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .busy(busy),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the external prefix adder
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

    function automatic logic [N:0] golden(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic cin, input logic sub);
        logic [N:0] r;
        if (sub) r = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
        else     r = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
        return r;
    endfunction

    task automatic check(input string tag, input logic [N:0] obs, input logic [N:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic cin, input logic sub);
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    endtask

    // Called at the negedge right after the accept edge; counts cycles to out_valid
    task automatic wait_done(output int lat, output logic [7:0] cins);
        lat = 0;
        cins = '0;
        while (!out_valid && lat < 64) begin
            if (lat < 8) cins[lat] = add_cin;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic cin, input logic sub, output logic [7:0] cins);
        int lat;
        @(negedge clk);
        check({tag, "_ready"}, {{N{1'b0}}, in_ready}, {{N{1'b0}}, 1'b1});
        drive(a, b, cin, sub);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(lat, cins);
        check({tag, "_lat"}, (N+1)'(lat), (N+1)'(WORDS));
        check({tag, "_res"}, {out_cout, out_sum}, golden(a, b, cin, sub));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_idle"}, {{(N-1){1'b0}}, out_valid, in_ready}, {{(N-1){1'b0}}, 2'b01});
    endtask

    initial begin
        logic [7:0]   cins;
        logic [N-1:0] hold_sum;
        logic         hold_cout;
        logic [N-1:0] ra, rb;
        int           lat;

        // 1: reset values
        #12;
        check("rst_state", {{(N-2){1'b0}}, in_ready, out_valid, busy},
              {{(N-2){1'b0}}, 3'b100});
        check("rst_adder", {{(N-2*WIDTH){1'b0}}, add_a, add_b, add_cin}, '0);
        check("rst_sum", {out_cout, out_sum}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_state", {{(N-2){1'b0}}, in_ready, out_valid, busy},
              {{(N-2){1'b0}}, 3'b100});

        // 2: full carry ripple
        run_op("ripple", {N{1'b1}}, '0, 1'b1, 1'b0, cins);
        check("ripple_cin", {{(N-3){1'b0}}, cins[3:0]}, {{(N-3){1'b0}}, 4'b1111});
        check("ripple_val", {out_cout, out_sum}, {1'b1, {N{1'b0}}});

        // 3: subtract cases
        run_op("sub_5_3", N'(5), N'(3), 1'b0, 1'b1, cins);
        check("sub_5_3_val", {out_cout, out_sum}, {1'b1, N'(2)});
        run_op("sub_3_5", N'(3), N'(5), 1'b1, 1'b1, cins);
        check("sub_3_5_val", {out_cout, out_sum}, {1'b0, {N{1'b1}} - N'(1)});
        run_op("sub_eq", N'(84'h123456789ABCDEF012345), N'(84'h123456789ABCDEF012345),
               1'b0, 1'b1, cins);
        check("sub_eq_val", {out_cout, out_sum}, {1'b1, {N{1'b0}}});

        // 4: backpressure with an ignored request in DONE
        @(negedge clk);
        drive(N'(84'h00F_0000_1234_5678_9ABC), N'(84'h0A0_1111_2222_3333_4444), 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(lat, cins);
        hold_sum = out_sum;
        hold_cout = out_cout;
        check("bp_res", {hold_cout, hold_sum},
              golden(N'(84'h00F_0000_1234_5678_9ABC), N'(84'h0A0_1111_2222_3333_4444), 1'b1, 1'b0));
        drive(N'(777), N'(1000), 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold", {out_cout, out_sum}, {hold_cout, hold_sum});
            check("bp_flags", {{(N-3){1'b0}}, in_ready, out_valid, busy, add_cin},
                  {{(N-3){1'b0}}, 4'b0110});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_idle", {{(N-2){1'b0}}, in_ready, out_valid, busy}, {{(N-2){1'b0}}, 3'b100});
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(lat, cins);
        check("bp_new_lat", (N+1)'(lat), (N+1)'(WORDS));
        check("bp_new_res", {out_cout, out_sum}, golden(N'(777), N'(1000), 1'b0, 1'b1));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // 5: reset in the middle of RUN at idx 2
        @(negedge clk);
        drive({N{1'b1}}, N'(12345), 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_busy", {{N{1'b0}}, busy}, {{N{1'b0}}, 1'b1});
        rst_n = 1'b0;
        #1;
        check("mid_rst_state", {{(N-2){1'b0}}, in_ready, out_valid, busy},
              {{(N-2){1'b0}}, 3'b100});
        check("mid_rst_adder", {{(N-2*WIDTH){1'b0}}, add_a, add_b, add_cin}, '0);
        check("mid_rst_sum", {out_cout, out_sum}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rel_ready", {{N{1'b0}}, in_ready}, {{N{1'b0}}, 1'b1});
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) lat++;
        end
        check("mid_no_valid", (N+1)'(lat), '0);
        run_op("post_rst", N'(84'hABCDE_12345_FFFFF_00001), N'(84'h54321_FEDCB_00001_FFFFF),
               1'b1, 1'b0, cins);

        // 6: random operations against the reference
        for (int k = 0; k < 50; k++) begin
            ra = N'({$urandom, $urandom, $urandom});
            rb = N'({$urandom, $urandom, $urandom});
            if (k % 10 == 3) rb = ra;
            run_op($sformatf("rnd%0d", k), ra, rb, 1'($urandom), 1'($urandom), cins);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
